// File: rtl/led_status_pkg.sv
// Shared mode encoding for the board status-LED driver and its channels.
package led_status_pkg;

   typedef logic [1:0] led_mode_t;

   localparam led_mode_t LED_MODE_OFF     = 2'b00;
   localparam led_mode_t LED_MODE_LEVEL   = 2'b01;
   localparam led_mode_t LED_MODE_STRETCH = 2'b10;
   localparam led_mode_t LED_MODE_BLINK   = 2'b11;

endpackage

// File: rtl/led_channel.sv
// One status-LED channel: event stretch counter plus the registered mode mux.
module led_channel
   import led_status_pkg::*;
#(
   parameter int STRETCH_TICKS = 50
) (
   input  logic      clk,
   input  logic      rstn,
   input  logic      tick,
   input  logic      phase,
   input  led_mode_t mode,
   input  logic      level,
   input  logic      evt,
   output logic      led
);

   localparam int CW = $clog2(STRETCH_TICKS + 1);
   localparam logic [CW-1:0] LOAD = CW'(STRETCH_TICKS);

   logic [CW-1:0] cnt;
   logic          led_next;

   // The counter runs regardless of mode so switching into STRETCH shows live state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (evt) begin
         cnt <= LOAD;
      end else if (tick && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   always_comb begin
      led_next = 1'b0;
      case (mode)
         LED_MODE_OFF:     led_next = 1'b0;
         LED_MODE_LEVEL:   led_next = level;
         LED_MODE_STRETCH: led_next = (cnt != '0) | evt;
         LED_MODE_BLINK:   led_next = level & phase;
         default:          led_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         led <= 1'b0;
      end else begin
         led <= led_next;
      end
   end

endmodule

// File: rtl/led_status_ctrl.sv
// Status-LED driver: shared prescaler tick and blink phase feeding N_LED channels.
module led_status_ctrl
   import led_status_pkg::*;
#(
   parameter int N_LED         = 2,
   parameter int PRESCALE      = 100000,
   parameter int STRETCH_TICKS = 50,
   parameter int BLINK_TICKS   = 250
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [2*N_LED-1:0] mode,
   input  logic [N_LED-1:0]   level,
   input  logic [N_LED-1:0]   evt,
   output logic               tick,
   output logic [N_LED-1:0]   led
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);
   localparam logic [BW-1:0] BLINK_LAST    = BW'(BLINK_TICKS - 1);

   logic [PW-1:0] presc;
   logic [BW-1:0] blink_cnt;
   logic          phase;

   // With PRESCALE=1 the counter sits at 0 and tick is high every cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         presc <= '0;
         tick  <= 1'b0;
      end else begin
         tick <= (presc == PRESCALE_LAST);
         if (presc == PRESCALE_LAST) begin
            presc <= '0;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (tick) begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   for (genvar i = 0; i < N_LED; i++) begin : g_chan
      led_channel #(
         .STRETCH_TICKS(STRETCH_TICKS)
      ) u_chan (
         .clk  (clk),
         .rstn (rstn),
         .tick (tick),
         .phase(phase),
         .mode (led_mode_t'(mode[2*i +: 2])),
         .level(level[i]),
         .evt  (evt[i]),
         .led  (led[i])
      );
   end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Bench for led_status_ctrl: history-based reference model of tick, blink and stretch.
module tb_led_status_ctrl;
   import led_status_pkg::*;

   localparam int N = 2;
   localparam int P = 4;
   localparam int S = 3;
   localparam int B = 2;
   localparam int MAXC = 1024;

   logic           clk = 1'b0;
   logic           rstn;
   logic [2*N-1:0] mode;
   logic [N-1:0]   level;
   logic [N-1:0]   evt;
   logic           tick;
   logic [N-1:0]   led;

   int checks = 0;
   int errors = 0;
   int n = 0;

   logic [2*N-1:0] mode_a  [MAXC];
   logic [N-1:0]   level_a [MAXC];
   logic [N-1:0]   evt_a   [MAXC];

   always #5 clk = ~clk;

   led_status_ctrl #(
      .N_LED(N), .PRESCALE(P), .STRETCH_TICKS(S), .BLINK_TICKS(B)
   ) dut (
      .clk(clk), .rstn(rstn), .mode(mode), .level(level), .evt(evt),
      .tick(tick), .led(led)
   );

   // Cycle index n counts clock edges since reset release; inputs of index i are seen at edge i+1.
   function automatic logic exp_tick(int m);
      return (m > 0) && (m % P == 0);
   endfunction

   function automatic int ticks_in(int a, int b);
      int c = 0;
      for (int m = a; m <= b; m++) if (exp_tick(m)) c++;
      return c;
   endfunction

   function automatic logic exp_phase(int k);
      return ((ticks_in(0, k - 1) / B) % 2) == 1;
   endfunction

   function automatic logic stretch_on(int ch, int i);
      for (int j = i - 1; j >= 0; j--) begin
         if (evt_a[j][ch]) return ticks_in(j + 1, i - 1) < S;
      end
      return 1'b0;
   endfunction

   function automatic logic [N-1:0] exp_led(int k);
      logic [N-1:0] r;
      led_mode_t md;
      int i;
      i = k - 1;
      r = '0;
      for (int ch = 0; ch < N; ch++) begin
         md = mode_a[i][2*ch +: 2];
         case (md)
            LED_MODE_LEVEL:   r[ch] = level_a[i][ch];
            LED_MODE_STRETCH: r[ch] = evt_a[i][ch] | stretch_on(ch, i);
            LED_MODE_BLINK:   r[ch] = level_a[i][ch] & exp_phase(i);
            default:          r[ch] = 1'b0;
         endcase
      end
      return r;
   endfunction

   task automatic advance();
      if (n >= MAXC) begin
         $display("FAIL history_overflow: n=%0d limit %0d", n, MAXC);
         $fatal(1);
      end
      mode_a[n]  = mode;
      level_a[n] = level;
      evt_a[n]   = evt;
      @(posedge clk);
      #1;
      n++;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      evt  = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      n = 0;
   endtask

   task automatic test_reset();
      rstn  = 1'b0;
      mode  = {LED_MODE_LEVEL, LED_MODE_LEVEL};
      level = 2'b11;
      evt   = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (led !== 2'b00) begin errors++; $display("FAIL reset_led: led=%b expected 00", led); end
      checks++;
      if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: tick=%b expected 0", tick); end
      rstn = 1'b1;
      n = 0;
      for (int c = 0; c < 9; c++) begin
         advance();
         checks++;
         if (led !== exp_led(n)) begin errors++; $display("FAIL reset_run_led n=%0d: led=%b expected %b", n, led, exp_led(n)); end
         checks++;
         if (tick !== exp_tick(n)) begin errors++; $display("FAIL reset_run_tick n=%0d: tick=%b expected %b", n, tick, exp_tick(n)); end
      end
   endtask

   task automatic test_stretch();
      int on_cycles = 0;
      mode  = {LED_MODE_OFF, LED_MODE_STRETCH};
      level = '0;
      do_reset();
      for (int c = 0; c < 20; c++) begin
         evt = (c == 1) ? 2'b01 : 2'b00;
         advance();
         if (led[0]) on_cycles++;
         checks++;
         if (led !== exp_led(n)) begin errors++; $display("FAIL stretch n=%0d: led=%b expected %b", n, led, exp_led(n)); end
      end
      checks++;
      if (on_cycles <= (S - 1) * P || on_cycles > S * P) begin
         errors++;
         $display("FAIL stretch_on_time: on=%0d cycles expected in (%0d,%0d]", on_cycles, (S - 1) * P, S * P);
      end
   endtask

   task automatic test_retrigger();
      mode  = {LED_MODE_OFF, LED_MODE_STRETCH};
      level = '0;
      do_reset();
      for (int c = 0; c < 26; c++) begin
         evt = (c == 1 || c == 8) ? 2'b01 : 2'b00;
         advance();
         checks++;
         if (led !== exp_led(n)) begin errors++; $display("FAIL retrigger n=%0d: led=%b expected %b", n, led, exp_led(n)); end
         if (n >= 2 && n <= 21) begin
            checks++;
            if (led[0] !== 1'b1) begin errors++; $display("FAIL retrigger_hold n=%0d: led0=%b expected 1", n, led[0]); end
         end
         if (n == 22) begin
            checks++;
            if (led[0] !== 1'b0) begin errors++; $display("FAIL retrigger_end n=%0d: led0=%b expected 0", n, led[0]); end
         end
      end
   endtask

   task automatic test_blink();
      mode  = {LED_MODE_BLINK, LED_MODE_LEVEL};
      level = 2'b11;
      do_reset();
      for (int c = 0; c < 44; c++) begin
         if (c == 40) level = 2'b01;
         advance();
         checks++;
         if (led !== exp_led(n)) begin errors++; $display("FAIL blink n=%0d: led=%b expected %b", n, led, exp_led(n)); end
         if (n == 10 || n == 17 || n == 26) begin
            checks++;
            if (led[1] !== 1'b1) begin errors++; $display("FAIL blink_high n=%0d: led1=%b expected 1", n, led[1]); end
         end
      end
   endtask

   task automatic test_mode_switch();
      mode  = {LED_MODE_OFF, LED_MODE_STRETCH};
      level = '0;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         evt = (c == 1) ? 2'b01 : 2'b00;
         mode[1:0] = (c == 4 || c == 5) ? LED_MODE_OFF : LED_MODE_STRETCH;
         advance();
         checks++;
         if (led !== exp_led(n)) begin errors++; $display("FAIL mode_switch n=%0d: led=%b expected %b", n, led, exp_led(n)); end
         if (n == 5) begin
            checks++;
            if (led[0] !== 1'b0) begin errors++; $display("FAIL mode_switch_off n=%0d: led0=%b expected 0", n, led[0]); end
         end
         if (n == 7) begin
            checks++;
            if (led[0] !== 1'b1) begin errors++; $display("FAIL mode_switch_back n=%0d: led0=%b expected 1", n, led[0]); end
         end
      end
   endtask

   task automatic test_random();
      level = '0;
      mode  = {LED_MODE_STRETCH, LED_MODE_STRETCH};
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if (c % 25 == 0) mode = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) level = 2'($urandom_range(0, 3));
         for (int ch = 0; ch < N; ch++) evt[ch] = ($urandom_range(0, 19) == 0);
         advance();
         checks++;
         if (led !== exp_led(n)) begin errors++; $display("FAIL random n=%0d: led=%b expected %b mode=%b", n, led, exp_led(n), mode_a[n-1]); end
      end
   endtask

   task automatic test_async_reset();
      mode  = {LED_MODE_LEVEL, LED_MODE_STRETCH};
      level = 2'b10;
      do_reset();
      for (int c = 0; c < 4; c++) begin
         evt = (c == 1) ? 2'b01 : 2'b00;
         advance();
      end
      checks++;
      if (led !== 2'b11 || tick !== 1'b1) begin
         errors++;
         $display("FAIL async_pre: led=%b tick=%b expected 11 and 1", led, tick);
      end
      #2;
      rstn = 1'b0;
      #1;
      checks++;
      if (led !== 2'b00) begin errors++; $display("FAIL async_led: led=%b expected 00", led); end
      checks++;
      if (tick !== 1'b0) begin errors++; $display("FAIL async_tick: tick=%b expected 0", tick); end
      @(posedge clk);
      #1;
      rstn = 1'b1;
      n = 0;
      for (int c = 0; c < 12; c++) begin
         advance();
         checks++;
         if (led !== exp_led(n)) begin errors++; $display("FAIL async_after_led n=%0d: led=%b expected %b", n, led, exp_led(n)); end
         checks++;
         if (tick !== exp_tick(n)) begin errors++; $display("FAIL async_after_tick n=%0d: tick=%b expected %b", n, tick, exp_tick(n)); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      rstn  = 1'b0;
      mode  = '0;
      level = '0;
      evt   = '0;
      test_reset();
      test_stretch();
      test_retrigger();
      test_blink();
      test_mode_switch();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
